// File: rtl/psdsqrt_seq.sv
// Sequencer for the iterative square-root core. It takes one operand at a time
// on a valid/ready handshake, issues the start pulse, and counts NBITSIN/2
// iteration cycles. It then issues the stop pulse, captures and range-checks the
// result, and holds it on a valid/ready output handshake.
module psdsqrt_seq #(
   parameter int unsigned NBITSIN = 32,
   parameter bit          CHECK   = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NBITSIN-1:0]   in_x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NBITSIN-1:0]   out_x,
   output logic [NBITSIN/2-1:0] out_sqrt,
   output logic                 out_err,
   output logic                 busy,
   output logic                 sq_start,
   output logic                 sq_stop,
   output logic [NBITSIN-1:0]   sq_xin,
   input  logic [NBITSIN/2-1:0] sq_sqrt
);

   localparam int unsigned NITER = NBITSIN / 2;
   localparam int unsigned CW    = (NITER > 1) ? $clog2(NITER) : 1;
   localparam int unsigned WX    = NBITSIN + 2;
   localparam int unsigned WS    = NBITSIN / 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_RUN     = 3'd2,
      S_STOP    = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NBITSIN-1:0]   opreg_q, opreg_d;
   logic [NBITSIN-1:0]   out_x_q, out_x_d;
   logic [WS-1:0]        out_sqrt_q, out_sqrt_d;
   logic                 out_err_q, out_err_d;
   logic                 in_ready_q, out_valid_q, busy_q, sq_start_q, sq_stop_q;

   logic [WX-1:0]        s_w, x_w, lo_w, hi_w;
   logic                 in_range_c;

   // Result range check: s^2 <= x < (s+1)^2, widened so (s+1)^2 cannot overflow
   always_comb begin
      s_w        = WX'(sq_sqrt);
      x_w        = WX'(opreg_q);
      lo_w       = s_w * s_w;
      hi_w       = (s_w + WX'(1)) * (s_w + WX'(1));
      in_range_c = (lo_w <= x_w) && (x_w < hi_w);
   end

   // Next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opreg_d    = opreg_q;
      out_x_d    = out_x_q;
      out_sqrt_d = out_sqrt_q;
      out_err_d  = out_err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               opreg_d = in_x;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NITER - 1)) state_d = S_STOP;
         end
         S_STOP: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            out_sqrt_d = sq_sqrt;
            out_x_d    = opreg_q;
            out_err_d  = CHECK && !in_range_c;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake/strobe flops (decoded from next state)
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         opreg_q     <= '0;
         out_x_q     <= '0;
         out_sqrt_q  <= '0;
         out_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sq_start_q  <= 1'b0;
         sq_stop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opreg_q     <= opreg_d;
         out_x_q     <= out_x_d;
         out_sqrt_q  <= out_sqrt_d;
         out_err_q   <= out_err_d;
         in_ready_q  <= (state_d == S_IDLE);
         out_valid_q <= (state_d == S_HOLD);
         busy_q      <= (state_d != S_IDLE);
         sq_start_q  <= (state_d == S_START);
         sq_stop_q   <= (state_d == S_STOP);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sq_start  = sq_start_q;
   assign sq_stop   = sq_stop_q;
   assign sq_xin    = opreg_q;
   assign out_x     = out_x_q;
   assign out_sqrt  = out_sqrt_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Bench for psdsqrt_seq: two 32-bit instances (checker on/off) sharing stimulus,
// one 8-bit instance, each with a behavioural square-root core attached.
module tb_psdsqrt_seq;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // 32-bit stimulus shared by dut0 (CHECK=1) and dut1 (CHECK=0)
   logic        in_valid0 = 1'b0;
   logic [31:0] in_x0 = '0;
   logic        out_ready0 = 1'b0;
   logic        in_ready0, out_valid0, out_err0, busy0, sq_start0, sq_stop0;
   logic [31:0] out_x0, sq_xin0;
   logic [15:0] out_sqrt0, sq_sqrt0;
   logic        in_ready1, out_valid1, out_err1, busy1, sq_start1, sq_stop1;
   logic [31:0] out_x1, sq_xin1;
   logic [15:0] out_sqrt1, sq_sqrt1;

   // 8-bit stimulus for dut2
   logic        in_valid2 = 1'b0;
   logic [7:0]  in_x2 = '0;
   logic        out_ready2 = 1'b0;
   logic        in_ready2, out_valid2, out_err2, busy2, sq_start2, sq_stop2;
   logic [7:0]  out_x2, sq_xin2;
   logic [3:0]  out_sqrt2, sq_sqrt2;

   logic        bad0 = 1'b0;

   psdsqrt_seq #(.NBITSIN(32), .CHECK(1'b1)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_x(in_x0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_x(out_x0), .out_sqrt(out_sqrt0),
      .out_err(out_err0), .busy(busy0), .sq_start(sq_start0), .sq_stop(sq_stop0),
      .sq_xin(sq_xin0), .sq_sqrt(sq_sqrt0));

   psdsqrt_seq #(.NBITSIN(32), .CHECK(1'b0)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready1), .in_x(in_x0),
      .out_valid(out_valid1), .out_ready(out_ready0), .out_x(out_x1), .out_sqrt(out_sqrt1),
      .out_err(out_err1), .busy(busy1), .sq_start(sq_start1), .sq_stop(sq_stop1),
      .sq_xin(sq_xin1), .sq_sqrt(sq_sqrt1));

   psdsqrt_seq #(.NBITSIN(8), .CHECK(1'b1)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_x(in_x2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_x(out_x2), .out_sqrt(out_sqrt2),
      .out_err(out_err2), .busy(busy2), .sq_start(sq_start2), .sq_stop(sq_stop2),
      .sq_xin(sq_xin2), .sq_sqrt(sq_sqrt2));

   function automatic logic [31:0] isqrt(input logic [63:0] x);
      logic [63:0] r;
      logic [63:0] t;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= x) r = t;
      end
      return r[31:0];
   endfunction

   // Behavioural cores: latch operand on the edge ending START, result on the edge ending STOP
   logic [31:0] c0_x, c1_x;
   logic [7:0]  c2_x;
   logic [31:0] r0, r1, r2;
   always @(posedge clock) begin
      if (reset) begin
         c0_x <= '0; c1_x <= '0; c2_x <= '0;
         sq_sqrt0 <= '0; sq_sqrt1 <= '0; sq_sqrt2 <= '0;
      end else begin
         if (sq_start0) c0_x <= sq_xin0;
         if (sq_start1) c1_x <= sq_xin1;
         if (sq_start2) c2_x <= sq_xin2;
         r0 = isqrt(64'(c0_x));
         r1 = isqrt(64'(c1_x));
         r2 = isqrt(64'(c2_x));
         if (sq_stop0) sq_sqrt0 <= (bad0 && c0_x == 32'h11) ? 16'd5 : r0[15:0];
         if (sq_stop1) sq_sqrt1 <= (c1_x == 32'h11) ? 16'd5 : r1[15:0];
         if (sq_stop2) sq_sqrt2 <= r2[3:0];
      end
   end

   typedef struct {
      logic [31:0] x;
      logic [15:0] s;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   // Offer x to dut0 and wait for out_valid; returns in HOLD at a negedge with cycle index
   task automatic run0(input logic [31:0] x, output int cyc, output bit ok);
      int w;
      ok = 1'b0; cyc = 0; w = 0;
      while (!in_ready0 && w < 50) begin @(negedge clock); w++; end
      if (!in_ready0) return;
      in_valid0 = 1'b1; in_x0 = x;
      while (cyc < 200 && !ok) begin
         @(negedge clock); cyc++;
         if (cyc == 1) in_valid0 = 1'b0;
         if (out_valid0) ok = 1'b1;
      end
      in_valid0 = 1'b0;
   endtask

   task automatic run2(input logic [7:0] x, output int cyc, output bit ok);
      int w;
      ok = 1'b0; cyc = 0; w = 0;
      while (!in_ready2 && w < 50) begin @(negedge clock); w++; end
      if (!in_ready2) return;
      in_valid2 = 1'b1; in_x2 = x;
      while (cyc < 100 && !ok) begin
         @(negedge clock); cyc++;
         if (cyc == 1) in_valid2 = 1'b0;
         if (out_valid2) ok = 1'b1;
      end
      in_valid2 = 1'b0;
   endtask

   task automatic xfer0();
      out_ready0 = 1'b1; @(negedge clock); out_ready0 = 1'b0;
   endtask

   task automatic xfer2();
      out_ready2 = 1'b1; @(negedge clock); out_ready2 = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] obs, req;
      obs = {in_ready0, out_valid0, busy0, sq_start0, sq_stop0, out_err0,
             (sq_xin0 == 0), (out_x0 == 0), (out_sqrt0 == 0), in_ready2};
      req = 10'b1000_0011_11;
      checks++;
      if (obs !== req) begin
         failures++; $display("FAIL reset_state0 got=%b want=%b", obs, req);
      end
      obs = {in_ready2, out_valid2, busy2, sq_start2, sq_stop2, out_err2,
             (sq_xin2 == 0), (out_x2 == 0), (out_sqrt2 == 0), in_ready1};
      checks++;
      if (obs !== req) begin
         failures++; $display("FAIL reset_state2 got=%b want=%b", obs, req);
      end
   endtask

   task automatic test_basic();
      int start_c, stop_c, valid_c, nstart, nstop;
      start_c = -1; stop_c = -1; valid_c = -1; nstart = 0; nstop = 0;
      sb.push_back('{x: 32'h11, s: 16'd4, err: 1'b0});
      checks++;
      if (in_ready0 !== 1'b1) begin
         failures++; $display("FAIL basic_in_ready got=%b want=1", in_ready0);
      end
      in_valid0 = 1'b1; in_x0 = 32'h11;
      for (int k = 1; k <= 40 && valid_c < 0; k++) begin
         @(negedge clock);
         if (k == 1) in_valid0 = 1'b0;
         if (sq_start0) begin nstart++; if (start_c < 0) start_c = k; end
         if (sq_stop0) begin nstop++; if (stop_c < 0) stop_c = k; end
         if (sq_start0 && sq_stop0) begin
            checks++; failures++; $display("FAIL basic_overlap start and stop both high at %0d", k);
         end
         if (out_valid0) valid_c = k;
      end
      checks++;
      if (start_c !== 1 || nstart !== 1) begin
         failures++; $display("FAIL basic_start cyc=%0d n=%0d want cyc=1 n=1", start_c, nstart);
      end
      checks++;
      if (stop_c !== 18 || nstop !== 1) begin
         failures++; $display("FAIL basic_stop cyc=%0d n=%0d want cyc=18 n=1", stop_c, nstop);
      end
      checks++;
      if (valid_c !== 20) begin
         failures++; $display("FAIL basic_latency got=%0d want=20", valid_c);
      end
      e = sb.pop_front();
      checks++;
      if (out_sqrt0 !== e.s || out_x0 !== e.x || out_err0 !== e.err) begin
         failures++;
         $display("FAIL basic_result got s=%h x=%h e=%b want s=%h x=%h e=%b",
                  out_sqrt0, out_x0, out_err0, e.s, e.x, e.err);
      end
      xfer0();
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
         failures++; $display("FAIL basic_release got v=%b r=%b b=%b want 0 1 0",
                              out_valid0, in_ready0, busy0);
      end
   endtask

   task automatic test_corners();
      logic [31:0] xs [8];
      logic [15:0] ss [8];
      logic [31:0] rv;
      int cyc; bit ok;
      xs[0] = 32'h0;        ss[0] = 16'h0;
      xs[1] = 32'hFFFFFFFF; ss[1] = 16'hFFFF;
      xs[2] = 32'hFFFE0001; ss[2] = 16'hFFFF;
      xs[3] = 32'hFFFE0000; ss[3] = 16'hFFFE;
      xs[4] = 32'h1;        ss[4] = 16'h1;
      xs[5] = 32'h3;        ss[5] = 16'h1;
      for (int i = 6; i < 8; i++) begin
         xs[i] = $urandom;
         rv = isqrt(64'(xs[i]));
         ss[i] = rv[15:0];
      end
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{x: xs[i], s: ss[i], err: 1'b0});
         run0(xs[i], cyc, ok);
         e = sb.pop_front();
         checks++;
         if (!ok) begin
            failures++; $display("FAIL corner_timeout x=%h", xs[i]);
         end else if (out_sqrt0 !== e.s || out_x0 !== e.x || out_err0 !== e.err) begin
            failures++;
            $display("FAIL corner_result x=%h got s=%h x=%h e=%b want s=%h e=%b",
                     e.x, out_sqrt0, out_x0, out_err0, e.s, e.err);
         end
         xfer0();
      end
   endtask

   task automatic test_stall();
      int cyc; bit ok; int bad;
      sb.push_back('{x: 32'h2710, s: 16'd100, err: 1'b0});
      run0(32'h2710, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stall_timeout first operand"); end
      e = sb.pop_front();
      in_valid0 = 1'b1; in_x0 = 32'h64;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_sqrt0 !== e.s ||
             out_x0 !== e.x || out_err0 !== 1'b0 || sq_xin0 !== e.x) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL stall_hold unstable_cycles=%0d want=0 (s=%h x=%h)",
                              bad, out_sqrt0, out_x0);
      end
      out_ready0 = 1'b1;
      @(negedge clock);
      out_ready0 = 1'b0;
      checks++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || sq_xin0 !== e.x) begin
         failures++; $display("FAIL stall_idle got r=%b v=%b xin=%h want 1 0 %h",
                              in_ready0, out_valid0, sq_xin0, e.x);
      end
      sb.push_back('{x: 32'h64, s: 16'd10, err: 1'b0});
      @(negedge clock);
      in_valid0 = 1'b0;
      checks++;
      if (sq_start0 !== 1'b1 || busy0 !== 1'b1 || sq_xin0 !== 32'h64) begin
         failures++; $display("FAIL stall_accept got st=%b b=%b xin=%h want 1 1 00000064",
                              sq_start0, busy0, sq_xin0);
      end
      cyc = 0; ok = 1'b0;
      while (cyc < 100 && !ok) begin @(negedge clock); cyc++; if (out_valid0) ok = 1'b1; end
      e = sb.pop_front();
      checks++;
      if (!ok || out_sqrt0 !== e.s || out_x0 !== e.x || out_err0 !== e.err) begin
         failures++; $display("FAIL stall_second ok=%b got s=%h x=%h want s=%h x=%h",
                              ok, out_sqrt0, out_x0, e.s, e.x);
      end
      xfer0();
   endtask

   task automatic test_reset_mid();
      int stops, busy_seen, cyc; bit ok;
      stops = 0; busy_seen = 0;
      sb.push_back('{x: 32'hFFFFFFFF, s: 16'hFFFF, err: 1'b0});
      in_valid0 = 1'b1; in_x0 = 32'hFFFFFFFF;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         if (k == 1) in_valid0 = 1'b0;
         if (sq_stop0) stops++;
      end
      checks++;
      if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
         failures++; $display("FAIL rst_mid_running got b=%b r=%b want 1 0", busy0, in_ready0);
      end
      reset = 1'b1; in_valid0 = 1'b1; in_x0 = 32'h90;
      @(negedge clock);
      sb.delete();
      reset = 1'b0; in_valid0 = 1'b0;
      checks++;
      if (busy0 !== 1'b0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || sq_start0 !== 1'b0 ||
          sq_stop0 !== 1'b0 || sq_xin0 !== 32'h0 || out_x0 !== 32'h0 || out_sqrt0 !== 16'h0 ||
          out_err0 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs got b=%b v=%b r=%b st=%b sp=%b xin=%h x=%h s=%h want 0 0 1 0 0 0 0 0",
                  busy0, out_valid0, in_ready0, sq_start0, sq_stop0, sq_xin0, out_x0, out_sqrt0);
      end
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (sq_stop0) stops++;
         if (busy0) busy_seen++;
      end
      checks++;
      if (stops != 0 || busy_seen != 0) begin
         failures++; $display("FAIL rst_mid_nostop stops=%0d busy=%0d want 0 0", stops, busy_seen);
      end
      sb.push_back('{x: 32'h90, s: 16'd12, err: 1'b0});
      run0(32'h90, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_sqrt0 !== e.s || out_x0 !== e.x || out_err0 !== e.err) begin
         failures++; $display("FAIL rst_mid_after ok=%b got s=%h x=%h want s=%h x=%h",
                              ok, out_sqrt0, out_x0, e.s, e.x);
      end
      xfer0();
   endtask

   task automatic test_bad_core();
      int cyc; bit ok;
      bad0 = 1'b1;
      sb.push_back('{x: 32'h11, s: 16'd5, err: 1'b1});
      run0(32'h11, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_valid0 !== 1'b1 || out_err0 !== e.err || out_sqrt0 !== e.s) begin
         failures++; $display("FAIL bad_core_check ok=%b got v=%b e=%b s=%h want 1 1 %h",
                              ok, out_valid0, out_err0, out_sqrt0, e.s);
      end
      checks++;
      if (out_valid1 !== 1'b1 || out_err1 !== 1'b0 || out_sqrt1 !== 16'd5) begin
         failures++; $display("FAIL bad_core_nocheck got v=%b e=%b s=%h want 1 0 0005",
                              out_valid1, out_err1, out_sqrt1);
      end
      xfer0();
      bad0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops [4];
      logic [31:0] rv;
      int idx, done, k, overlap;
      ops[0] = 32'h19; ops[1] = 32'h3E8; ops[2] = 32'hFFFFFFFF; ops[3] = $urandom;
      idx = 0; done = 0; k = 0; overlap = 0;
      out_ready0 = 1'b1;
      while (done < 4 && k < 400) begin
         if (out_valid0) begin
            e = sb.pop_front();
            done++;
            checks++;
            if (out_sqrt0 !== e.s || out_x0 !== e.x || out_err0 !== e.err) begin
               failures++; $display("FAIL b2b_result got s=%h x=%h e=%b want s=%h x=%h e=%b",
                                    out_sqrt0, out_x0, out_err0, e.s, e.x, e.err);
            end
         end
         if (in_ready0 && busy0) overlap++;
         if (in_ready0 && idx < 4) begin
            rv = isqrt(64'(ops[idx]));
            sb.push_back('{x: ops[idx], s: rv[15:0], err: 1'b0});
            in_valid0 = 1'b1; in_x0 = ops[idx]; idx++;
         end else begin
            in_valid0 = 1'b0;
         end
         @(negedge clock); k++;
      end
      out_ready0 = 1'b0; in_valid0 = 1'b0;
      checks++;
      if (done != 4 || overlap != 0) begin
         failures++; $display("FAIL b2b_count done=%0d overlap=%0d want 4 0", done, overlap);
      end
      @(negedge clock);
   endtask

   task automatic test_narrow();
      int cyc; bit ok; int bad;
      logic [31:0] rv;
      run2(8'hC8, cyc, ok);
      checks++;
      if (!ok || cyc != 8 || out_sqrt2 !== 4'd14 || out_x2 !== 8'hC8 || out_err2 !== 1'b0) begin
         failures++; $display("FAIL narrow_c8 ok=%b cyc=%0d s=%h x=%h e=%b want cyc=8 s=e x=c8 e=0",
                              ok, cyc, out_sqrt2, out_x2, out_err2);
      end
      xfer2();
      bad = 0;
      for (int v = 0; v < 256; v++) begin
         rv = isqrt(64'(v));
         run2(8'(v), cyc, ok);
         if (!ok || out_sqrt2 !== rv[3:0] || out_x2 !== 8'(v) || out_err2 !== 1'b0) begin
            if (bad < 4) $display("FAIL narrow_sweep x=%0d got s=%0d e=%b want s=%0d",
                                  v, out_sqrt2, out_err2, rv[3:0]);
            bad++;
         end
         xfer2();
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL narrow_sweep_total bad=%0d want=0", bad);
      end
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clock);
      test_reset();
      reset = 1'b0;
      @(negedge clock);
      test_reset();
      test_basic();
      test_corners();
      test_stall();
      test_reset_mid();
      test_bad_core();
      test_back_to_back();
      test_narrow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
